// File: rtl/axi_wb_arbiter.sv
// Two-port AXI (instruction/data) to single Wishbone classic master bridge.
// One AXI transaction is served at a time; ports are arbitrated round-robin,
// bursts are walked beat by beat and partial writes use read-modify-write.
module axi_wb_arbiter #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned RR_INIT  = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // instruction port
    input  logic                inst_awvalid_i,
    input  logic [31:0]         inst_awaddr_i,
    input  logic [ID_WIDTH-1:0] inst_awid_i,
    input  logic [7:0]          inst_awlen_i,
    input  logic [1:0]          inst_awburst_i,
    output logic                inst_awready_o,
    input  logic                inst_wvalid_i,
    input  logic [31:0]         inst_wdata_i,
    input  logic [3:0]          inst_wstrb_i,
    input  logic                inst_wlast_i,
    output logic                inst_wready_o,
    output logic                inst_bvalid_o,
    output logic [1:0]          inst_bresp_o,
    output logic [ID_WIDTH-1:0] inst_bid_o,
    input  logic                inst_bready_i,
    input  logic                inst_arvalid_i,
    input  logic [31:0]         inst_araddr_i,
    input  logic [ID_WIDTH-1:0] inst_arid_i,
    input  logic [7:0]          inst_arlen_i,
    input  logic [1:0]          inst_arburst_i,
    output logic                inst_arready_o,
    output logic                inst_rvalid_o,
    output logic [31:0]         inst_rdata_o,
    output logic [1:0]          inst_rresp_o,
    output logic [ID_WIDTH-1:0] inst_rid_o,
    output logic                inst_rlast_o,
    input  logic                inst_rready_i,
    // data port
    input  logic                data_awvalid_i,
    input  logic [31:0]         data_awaddr_i,
    input  logic [ID_WIDTH-1:0] data_awid_i,
    input  logic [7:0]          data_awlen_i,
    input  logic [1:0]          data_awburst_i,
    output logic                data_awready_o,
    input  logic                data_wvalid_i,
    input  logic [31:0]         data_wdata_i,
    input  logic [3:0]          data_wstrb_i,
    input  logic                data_wlast_i,
    output logic                data_wready_o,
    output logic                data_bvalid_o,
    output logic [1:0]          data_bresp_o,
    output logic [ID_WIDTH-1:0] data_bid_o,
    input  logic                data_bready_i,
    input  logic                data_arvalid_i,
    input  logic [31:0]         data_araddr_i,
    input  logic [ID_WIDTH-1:0] data_arid_i,
    input  logic [7:0]          data_arlen_i,
    input  logic [1:0]          data_arburst_i,
    output logic                data_arready_o,
    output logic                data_rvalid_o,
    output logic [31:0]         data_rdata_o,
    output logic [1:0]          data_rresp_o,
    output logic [ID_WIDTH-1:0] data_rid_o,
    output logic                data_rlast_o,
    input  logic                data_rready_i,
    // Wishbone classic master
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [31:0]         wb_addr_o,
    output logic [31:0]         wb_data_o,
    input  logic [31:0]         wb_data_i,
    input  logic                wb_ack_i
);

    typedef enum logic [2:0] {IDLE, RD_BUS, RD_RESP, WR_DATA, WR_RMW, WR_BUS, WR_RESP} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, sel_q, cyc_q, cyc_d;
    logic [31:0]         addr_q, data_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q, beat_q;
    logic [1:0]          burst_q;
    logic [3:0]          wstrb_q;

    logic                inst_req, data_req, grant_data, grant_ok, grant_aw;
    logic [31:0]         req_addr;
    logic [ID_WIDTH-1:0] req_id;
    logic [7:0]          req_len;
    logic [1:0]          req_burst;
    logic                wvalid, rready, bready, bus_done, last_beat, beat_adv;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;

    // Beat count comes from awlen alone, so wlast carries no information here.
    logic unused_wlast;
    assign unused_wlast = inst_wlast_i ^ data_wlast_i;

    // Address of the following beat for the latched burst type; the reserved
    // encoding and unsupported wrap lengths advance like INCR.
    function automatic logic [31:0] next_beat_addr(input logic [31:0] a, input logic [7:0] l,
                                                   input logic [1:0] b);
        logic [31:0] mask;
        mask = {22'd0, l, 2'b11};
        if (b == 2'b00) return a;
        if (b == 2'b10 && (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15))
            return (a & ~mask) | ((a + 32'd4) & mask);
        return a + 32'd4;
    endfunction

    // The port that was not granted last wins a tie; AW beats AR within a port.
    assign inst_req   = inst_awvalid_i | inst_arvalid_i;
    assign data_req   = data_awvalid_i | data_arvalid_i;
    assign grant_data = data_req && (!inst_req || !last_grant_q);
    assign grant_ok   = (state_q == IDLE) && !rst_i && (inst_req || data_req);
    assign grant_aw   = grant_data ? data_awvalid_i : inst_awvalid_i;

    // Select the address-channel fields of the winning request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_addr  = inst_araddr_i;
        req_id    = inst_arid_i;
        req_len   = inst_arlen_i;
        req_burst = inst_arburst_i;
        case ({grant_data, grant_aw})
            2'b01: begin req_addr = inst_awaddr_i; req_id = inst_awid_i;
                         req_len = inst_awlen_i;   req_burst = inst_awburst_i; end
            2'b10: begin req_addr = data_araddr_i; req_id = data_arid_i;
                         req_len = data_arlen_i;   req_burst = data_arburst_i; end
            2'b11: begin req_addr = data_awaddr_i; req_id = data_awid_i;
                         req_len = data_awlen_i;   req_burst = data_awburst_i; end
            default: ;
        endcase
    end

    assign wvalid    = sel_q ? data_wvalid_i : inst_wvalid_i;
    assign wdata     = sel_q ? data_wdata_i  : inst_wdata_i;
    assign wstrb     = sel_q ? data_wstrb_i  : inst_wstrb_i;
    assign rready    = sel_q ? data_rready_i : inst_rready_i;
    assign bready    = sel_q ? data_bready_i : inst_bready_i;
    assign bus_done  = cyc_q & wb_ack_i;
    assign last_beat = (beat_q == len_q);

    // Next-state logic, beat advance and the next value of the bus strobe.
    always_comb begin
        state_d  = state_q;
        beat_adv = 1'b0;
        cyc_d    = 1'b0;
        case (state_q)
            IDLE:    if (grant_ok) state_d = grant_aw ? WR_DATA : RD_BUS;
            RD_BUS: begin
                cyc_d = !bus_done;
                if (bus_done) state_d = RD_RESP;
            end
            RD_RESP: if (rready) begin
                state_d  = last_beat ? IDLE : RD_BUS;
                beat_adv = !last_beat;
            end
            WR_DATA: if (wvalid) begin
                if (wstrb == 4'hF) state_d = WR_BUS;
                else if (wstrb == 4'h0) begin
                    state_d  = last_beat ? WR_RESP : WR_DATA;
                    beat_adv = !last_beat;
                end else state_d = WR_RMW;
            end
            WR_RMW: begin
                cyc_d = !bus_done;
                if (bus_done) state_d = WR_BUS;
            end
            WR_BUS: begin
                cyc_d = !bus_done;
                if (bus_done) begin
                    state_d  = last_beat ? WR_RESP : WR_DATA;
                    beat_adv = !last_beat;
                end
            end
            WR_RESP: if (bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Transaction context, beat tracking and the shared data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= (RR_INIT != 0);
            sel_q        <= 1'b0;
            cyc_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            id_q         <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            cyc_q <= cyc_d;
            if (grant_ok) begin
                last_grant_q <= grant_data;
                sel_q        <= grant_data;
                addr_q       <= req_addr;
                id_q         <= req_id;
                len_q        <= req_len;
                burst_q      <= req_burst;
                beat_q       <= '0;
            end
            if (beat_adv) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_beat_addr(addr_q, len_q, burst_q);
            end
            if (state_q == RD_BUS && bus_done) data_q <= wb_data_i;
            if (state_q == WR_DATA && wvalid) begin
                data_q  <= wdata;
                wstrb_q <= wstrb;
            end
            if (state_q == WR_RMW && bus_done)
                for (int i = 0; i < 4; i++)
                    if (!wstrb_q[i]) data_q[8*i +: 8] <= wb_data_i[8*i +: 8];
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = cyc_q && (state_q == WR_BUS);
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;

    assign inst_awready_o = grant_ok && !grant_data && inst_awvalid_i;
    assign inst_arready_o = grant_ok && !grant_data && !inst_awvalid_i && inst_arvalid_i;
    assign data_awready_o = grant_ok && grant_data && data_awvalid_i;
    assign data_arready_o = grant_ok && grant_data && !data_awvalid_i && data_arvalid_i;

    assign inst_wready_o = (state_q == WR_DATA) && !sel_q;
    assign data_wready_o = (state_q == WR_DATA) &&  sel_q;
    assign inst_bvalid_o = (state_q == WR_RESP) && !sel_q;
    assign data_bvalid_o = (state_q == WR_RESP) &&  sel_q;
    assign inst_rvalid_o = (state_q == RD_RESP) && !sel_q;
    assign data_rvalid_o = (state_q == RD_RESP) &&  sel_q;
    assign inst_rlast_o  = inst_rvalid_o && last_beat;
    assign data_rlast_o  = data_rvalid_o && last_beat;

    assign inst_bresp_o = 2'b00;
    assign data_bresp_o = 2'b00;
    assign inst_rresp_o = 2'b00;
    assign data_rresp_o = 2'b00;
    assign inst_bid_o   = id_q;
    assign data_bid_o   = id_q;
    assign inst_rid_o   = id_q;
    assign data_rid_o   = id_q;
    assign inst_rdata_o = data_q;
    assign data_rdata_o = data_q;

endmodule

// File: tb/tb_axi_wb_arbiter.sv
// Scoreboard bench for axi_wb_arbiter: expected Wishbone accesses, read beats
// and write responses are queued when stimulus is issued and popped by monitors.
module tb_axi_wb_arbiter;

    localparam int IDW = 4;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct { int port; logic [31:0] data; logic last; logic [IDW-1:0] id; } rbeat_t;
    typedef struct { int port; logic [IDW-1:0] id; } bexp_t;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]     awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0]    awaddr[2], wdata[2], araddr[2];
    logic [IDW-1:0] awid[2], arid[2];
    logic [7:0]     awlen[2], arlen[2];
    logic [1:0]     awburst[2], arburst[2];
    logic [3:0]     wstrb[2];

    logic [1:0]     awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]     bresp[2], rresp[2];
    logic [IDW-1:0] bid[2], rid[2];
    logic [31:0]    rdata[2];

    logic           wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0]    wb_addr, wb_dat_o, wb_dat_i;

    bus_t   exp_bus[$];
    rbeat_t exp_r[$];
    bexp_t  exp_b[$];
    int     grant_seq[$];
    int     grant_rdone[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int n_checks = 0;
    int n_pass   = 0;
    int r_done   = 0;
    bit ack_en   = 1'b1;
    bit inject_ack = 1'b0;

    axi_wb_arbiter #(.ID_WIDTH(IDW), .RR_INIT(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_awvalid_i(awvalid[0]), .inst_awaddr_i(awaddr[0]), .inst_awid_i(awid[0]),
        .inst_awlen_i(awlen[0]), .inst_awburst_i(awburst[0]), .inst_awready_o(awready[0]),
        .inst_wvalid_i(wvalid[0]), .inst_wdata_i(wdata[0]), .inst_wstrb_i(wstrb[0]),
        .inst_wlast_i(wlast[0]), .inst_wready_o(wready[0]),
        .inst_bvalid_o(bvalid[0]), .inst_bresp_o(bresp[0]), .inst_bid_o(bid[0]),
        .inst_bready_i(bready[0]),
        .inst_arvalid_i(arvalid[0]), .inst_araddr_i(araddr[0]), .inst_arid_i(arid[0]),
        .inst_arlen_i(arlen[0]), .inst_arburst_i(arburst[0]), .inst_arready_o(arready[0]),
        .inst_rvalid_o(rvalid[0]), .inst_rdata_o(rdata[0]), .inst_rresp_o(rresp[0]),
        .inst_rid_o(rid[0]), .inst_rlast_o(rlast[0]), .inst_rready_i(rready[0]),
        .data_awvalid_i(awvalid[1]), .data_awaddr_i(awaddr[1]), .data_awid_i(awid[1]),
        .data_awlen_i(awlen[1]), .data_awburst_i(awburst[1]), .data_awready_o(awready[1]),
        .data_wvalid_i(wvalid[1]), .data_wdata_i(wdata[1]), .data_wstrb_i(wstrb[1]),
        .data_wlast_i(wlast[1]), .data_wready_o(wready[1]),
        .data_bvalid_o(bvalid[1]), .data_bresp_o(bresp[1]), .data_bid_o(bid[1]),
        .data_bready_i(bready[1]),
        .data_arvalid_i(arvalid[1]), .data_araddr_i(araddr[1]), .data_arid_i(arid[1]),
        .data_arlen_i(arlen[1]), .data_arburst_i(arburst[1]), .data_arready_o(arready[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_rresp_o(rresp[1]),
        .data_rid_o(rid[1]), .data_rlast_o(rlast[1]), .data_rready_i(rready[1]),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_addr_o(wb_addr),
        .wb_data_o(wb_dat_o), .wb_data_i(wb_dat_i), .wb_ack_i(wb_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Contents of untouched memory locations, derived from the address.
    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Independent burst model: wrap bursts stay inside a (len+1)*4 aligned window.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] size, base;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            size = ({24'd0, len} + 32'd1) * 32'd4;
            base = start - (start % size);
            return base + ((start - base + 32'(4 * i)) % size);
        end
        return start + 32'(4 * i);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic push_read(input int p, input logic [31:0] a, input logic [IDW-1:0] id,
                             input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] ba, d;
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, burst, i);
            d  = ref_rd(ba);
            exp_bus.push_back('{we: 1'b0, addr: ba, data: d});
            exp_r.push_back('{port: p, data: d, last: (i == int'(len)), id: id});
        end
    endtask

    task automatic issue_ar(input int p, input logic [31:0] a, input logic [IDW-1:0] id,
                            input logic [7:0] len, input logic [1:0] burst);
        bit granted = 1'b0;
        @(posedge clk); #1;
        arvalid[p] = 1'b1; araddr[p] = a; arid[p] = id; arlen[p] = len; arburst[p] = burst;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (arready[p]) begin granted = 1'b1; break; end
        end
        check($sformatf("ar_grant_p%0d", p), 64'(granted), 64'd1);
        grant_seq.push_back(p);
        grant_rdone.push_back(r_done);
        @(posedge clk); #1;
        arvalid[p] = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_bus.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0) break;
        end
        check("drain", 64'(exp_bus.size() + exp_r.size() + exp_b.size()), 64'd0);
    endtask

    task automatic do_read(input int p, input logic [31:0] a, input logic [IDW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
        push_read(p, a, id, len, burst);
        issue_ar(p, a, id, len, burst);
        wait_done();
    endtask

    task automatic do_write(input int p, input logic [31:0] a, input logic [IDW-1:0] id,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] ba, bd, old, m;
        bit ok;
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, burst, i);
            bd = d + 32'(i);
            if (strb == 4'hF) begin
                exp_bus.push_back('{we: 1'b1, addr: ba, data: bd});
                ref_mem[ba] = bd;
            end else if (strb != 4'h0) begin
                old = ref_rd(ba);
                m   = merge(old, bd, strb);
                exp_bus.push_back('{we: 1'b0, addr: ba, data: old});
                exp_bus.push_back('{we: 1'b1, addr: ba, data: m});
                ref_mem[ba] = m;
            end
        end
        exp_b.push_back('{port: p, id: id});
        @(posedge clk); #1;
        awvalid[p] = 1'b1; awaddr[p] = a; awid[p] = id; awlen[p] = len; awburst[p] = burst;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (awready[p]) begin ok = 1'b1; break; end
        end
        check($sformatf("aw_grant_p%0d", p), 64'(ok), 64'd1);
        @(posedge clk); #1;
        awvalid[p] = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid[p] = 1'b1; wdata[p] = d + 32'(i); wstrb[p] = strb; wlast[p] = (i == int'(len));
            ok = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (wready[p]) begin ok = 1'b1; break; end
            end
            check("w_ready", 64'(ok), 64'd1);
            @(posedge clk); #1;
            wvalid[p] = 1'b0;
        end
        wait_done();
    endtask

    // Wishbone slave: acks one cycle after stb and checks each access in order.
    initial begin
        bus_t e;
        wb_ack = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (wb_ack) wb_ack = 1'b0;
            else if (inject_ack) begin
                wb_ack = 1'b1;
                inject_ack = 1'b0;
            end else if (ack_en && wb_cyc && wb_stb) begin
                check("bus_pending", 64'(exp_bus.size() != 0), 64'd1);
                if (exp_bus.size() != 0) begin
                    e = exp_bus.pop_front();
                    check("bus_we", 64'(wb_we), 64'(e.we));
                    check("bus_addr", 64'(wb_addr), 64'(e.addr));
                    if (e.we) check("bus_wdata", 64'(wb_dat_o), 64'(e.data));
                end
                if (wb_we) mem[wb_addr] = wb_dat_o;
                else wb_dat_i = mem.exists(wb_addr) ? mem[wb_addr] : fill(wb_addr);
                wb_ack = 1'b1;
            end
        end
    end

    // Read-data monitor: every accepted beat is matched against the scoreboard.
    initial begin
        rbeat_t e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (rvalid[p] && rready[p]) begin
                    check("r_pending", 64'(exp_r.size() != 0), 64'd1);
                    check("r_other_quiet", 64'(rvalid[1-p]), 64'd0);
                    if (exp_r.size() != 0) begin
                        e = exp_r.pop_front();
                        check("r_port", 64'(p), 64'(e.port));
                        check("r_data", 64'(rdata[p]), 64'(e.data));
                        check("r_last", 64'(rlast[p]), 64'(e.last));
                        check("r_id", 64'(rid[p]), 64'(e.id));
                        check("r_resp", 64'(rresp[p]), 64'd0);
                    end
                    r_done++;
                end
            end
        end
    end

    // Write-response monitor.
    initial begin
        bexp_t e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (bvalid[p] && bready[p]) begin
                    check("b_pending", 64'(exp_b.size() != 0), 64'd1);
                    if (exp_b.size() != 0) begin
                        e = exp_b.pop_front();
                        check("b_port", 64'(p), 64'(e.port));
                        check("b_id", 64'(bid[p]), 64'(e.id));
                        check("b_resp", 64'(bresp[p]), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_base;
        bit seen;
        rst = 1'b1;
        awvalid = '0; wvalid = '0; wlast = '0; arvalid = '0;
        bready = 2'b11; rready = 2'b11;
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = '0; awid[p] = '0; awlen[p] = '0; awburst[p] = '0;
            araddr[p] = '0; arid[p] = '0; arlen[p] = '0; arburst[p] = '0;
            wdata[p] = '0; wstrb[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cyc_stb_we", 64'({wb_cyc, wb_stb, wb_we}), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_dat_o), 64'd0);
        check("rst_rdata", 64'(rdata[0]), 64'd0);
        check("rst_handshakes", 64'({rvalid, bvalid, wready, awready, arready}), 64'd0);

        // Both ports request at once: data wins first, inst after data's last beat.
        r_base = r_done;
        push_read(1, 32'h200, 4'd5, 8'd1, 2'b01);
        push_read(0, 32'h400, 4'd3, 8'd1, 2'b01);
        fork
            issue_ar(0, 32'h400, 4'd3, 8'd1, 2'b01);
            issue_ar(1, 32'h200, 4'd5, 8'd1, 2'b01);
        join
        wait_done();
        check("arb_first_data", 64'(grant_seq[0]), 64'd1);
        check("arb_second_inst", 64'(grant_seq[1]), 64'd0);
        check("arb_inst_after_data", 64'(grant_rdone[1] - r_base), 64'd2);

        // INCR, FIXED and WRAP reads.
        do_read(0, 32'h100, 4'd1, 8'd3, 2'b01);
        do_read(1, 32'h1C,  4'd2, 8'd3, 2'b10);
        do_read(0, 32'h50,  4'd4, 8'd1, 2'b00);

        // Partial-strobe read-modify-write.
        preload(32'h20, 32'h1122_3344);
        do_write(1, 32'h20, 4'd6, 8'd0, 2'b01, 32'h0000_AB00, 4'b0010);
        check("rmw_result", 64'(mem[32'h20]), 64'h1122_AB44);

        // Full-strobe burst write, read back; then a write with no strobes.
        do_write(0, 32'h80, 4'd7, 8'd1, 2'b01, 32'hCAFE_0000, 4'hF);
        do_read(0, 32'h80, 4'd8, 8'd1, 2'b01);
        do_write(1, 32'h90, 4'd9, 8'd0, 2'b01, 32'hDEAD_BEEF, 4'h0);

        // Back-pressure on rready: the beat is held and the bus stays quiet.
        @(posedge clk); #1 rready[0] = 1'b0;
        push_read(0, 32'h600, 4'd10, 8'd1, 2'b01);
        issue_ar(0, 32'h600, 4'd10, 8'd1, 2'b01);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rvalid[0]) begin seen = 1'b1; break; end
        end
        check("stall_rvalid_seen", 64'(seen), 64'd1);
        if (seen && exp_r.size() != 0) begin
            for (int c = 0; c < 5; c++) begin
                check("stall_rvalid", 64'(rvalid[0]), 64'd1);
                check("stall_rdata", 64'(rdata[0]), 64'(exp_r[0].data));
                check("stall_rlast", 64'(rlast[0]), 64'(exp_r[0].last));
                check("stall_no_bus", 64'(wb_cyc), 64'd0);
                @(negedge clk);
            end
        end
        @(posedge clk); #1 rready[0] = 1'b1;
        wait_done();

        // Reset while a read is on the bus; a late ack must be ignored.
        ack_en = 1'b0;
        issue_ar(0, 32'h300, 4'd11, 8'd0, 2'b01);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (wb_stb) break;
        end
        check("rst_mid_stb_seen", 64'(wb_stb), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc_stb", 64'({wb_cyc, wb_stb}), 64'd0);
        check("rst_mid_rvalid", 64'(rvalid), 64'd0);
        check("rst_mid_wb_addr", 64'(wb_addr), 64'd0);
        @(posedge clk); #1 inject_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("late_ack_cyc", 64'(wb_cyc), 64'd0);
            check("late_ack_rvalid", 64'(rvalid), 64'd0);
        end
        ack_en = 1'b1;
        do_read(0, 32'h300, 4'd12, 8'd0, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
